// File: rtl/mb_alu_pkg.sv
// Shared definitions for the multi-byte ALU controller: op-codes, FSM
// state type, default operand width and small op-code helpers.
package mb_alu_pkg;

   localparam int MAX_BYTES_DEF = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2
   } state_t;

   // Op-codes above OP_XOR are reserved and reported as errors.
   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_XOR);
   endfunction

   // Add and sub use the carry chain and produce C/V flags.
   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/mb_alu_ctrl_alu.sv
// Team 8-bit ALU: registered, one-cycle latency. Issues only when i_en is
// high; otherwise the previous result is held.
module mb_alu_ctrl_alu
   import mb_alu_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [2:0] i_op,
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_cin,
   output logic [7:0] o_y,
   output logic       o_c,
   output logic       o_v,
   output logic       o_z
);

   logic [8:0] sum9;
   logic [8:0] diff9;
   logic [7:0] y_d;
   logic       c_d;
   logic       v_d;

   // Combinational byte operation; for sub the carry output is a borrow.
   always_comb begin
      sum9  = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_cin};
      diff9 = {1'b0, i_a} - {1'b0, i_b} - {8'b0, i_cin};
      y_d   = 8'h00;
      c_d   = 1'b0;
      v_d   = 1'b0;
      case (i_op)
         OP_ADD: begin
            y_d = sum9[7:0];
            c_d = sum9[8];
            v_d = (i_a[7] == i_b[7]) && (y_d[7] != i_a[7]);
         end
         OP_SUB: begin
            y_d = diff9[7:0];
            c_d = diff9[8];
            v_d = (i_a[7] != i_b[7]) && (y_d[7] != i_a[7]);
         end
         OP_AND:  y_d = i_a & i_b;
         OP_OR:   y_d = i_a | i_b;
         OP_XOR:  y_d = i_a ^ i_b;
         default: y_d = 8'h00;
      endcase
   end

   // Output register: one-cycle latency from issue to result.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_y <= 8'h00;
         o_c <= 1'b0;
         o_v <= 1'b0;
         o_z <= 1'b0;
      end else if (i_en) begin
         o_y <= y_d;
         o_c <= c_d;
         o_v <= v_d;
         o_z <= (y_d == 8'h00);
      end
   end

endmodule

// File: rtl/mb_alu_ctrl.sv
// Multi-byte ALU controller: runs an add/sub/and/or/xor over up to
// MAX_BYTES bytes through a single registered 8-bit ALU, one byte per
// EXEC/CAPT pair, rippling the carry between bytes.
// Optional feature: define MB_ALU_CTRL_ABORT_EN to add the i_abort input,
// which cancels an operation in flight without a done pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; illegal op-codes are answered here directly
// EXEC  | byte[idx] of both operands and the chain carry issued to the ALU
// CAPT  | ALU result stored into byte[idx]; next byte or finish
module mb_alu_ctrl
   import mb_alu_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [2:0]             i_op,
   input  logic [1:0]             i_len,
   input  logic [8*MAX_BYTES-1:0] i_a,
   input  logic [8*MAX_BYTES-1:0] i_b,
   input  logic                   i_carry_in,
`ifdef MB_ALU_CTRL_ABORT_EN
   input  logic                   i_abort,
`endif
   output logic                   o_busy,
   output logic                   o_done,
   output logic [8*MAX_BYTES-1:0] o_result,
   output logic                   o_carry_borrow,
   output logic                   o_overflow,
   output logic                   o_neg,
   output logic                   o_zero,
   output logic                   o_err
);

   localparam logic [1:0] LEN_MAX = 2'(MAX_BYTES - 1);

   state_t                      state_q;
   state_t                      state_d;
   logic [2:0]                  op_q;
   logic [1:0]                  len_q;
   logic [1:0]                  idx_q;
   logic [MAX_BYTES-1:0][7:0]   a_q;
   logic [MAX_BYTES-1:0][7:0]   b_q;
   logic [MAX_BYTES-1:0][7:0]   res_q;
   logic [MAX_BYTES-1:0][7:0]   res_next;
   logic                        carry_q;
   logic                        zero_q;
   logic [1:0]                  len_clamped;
   logic                        last_byte;
   logic                        abort;
   logic                        alu_en;
   logic [7:0]                  alu_y;
   logic                        alu_c;
   logic                        alu_v;
   logic                        alu_z;

`ifdef MB_ALU_CTRL_ABORT_EN
   assign abort = i_abort;
`else
   assign abort = 1'b0;
`endif

   // A length beyond the instantiated width is clipped to the widest operand.
   assign len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;
   assign last_byte   = (idx_q == len_q);
   assign alu_en      = (state_q == EXEC);
   assign o_busy      = (state_q != IDLE);

   mb_alu_ctrl_alu u_alu (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (alu_en),
      .i_op    (op_q),
      .i_a     (a_q[idx_q]),
      .i_b     (b_q[idx_q]),
      .i_cin   (carry_q),
      .o_y     (alu_y),
      .o_c     (alu_c),
      .o_v     (alu_v),
      .o_z     (alu_z)
   );

   // Result accumulator with the byte currently returned by the ALU merged in.
   always_comb begin
      res_next        = res_q;
      res_next[idx_q] = alu_y;
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; illegal op-codes never leave IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_start && op_legal(i_op)) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = abort ? IDLE : CAPT;
         end
         CAPT: begin
            if (abort || last_byte) begin
               state_d = IDLE;
            end else begin
               state_d = EXEC;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, byte sequencing, carry chain and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q           <= OP_ADD;
         len_q          <= 2'd0;
         idx_q          <= 2'd0;
         a_q            <= '0;
         b_q            <= '0;
         res_q          <= '0;
         carry_q        <= 1'b0;
         zero_q         <= 1'b0;
         o_done         <= 1'b0;
         o_result       <= '0;
         o_carry_borrow <= 1'b0;
         o_overflow     <= 1'b0;
         o_neg          <= 1'b0;
         o_zero         <= 1'b0;
         o_err          <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  if (op_legal(i_op)) begin
                     op_q    <= i_op;
                     len_q   <= len_clamped;
                     a_q     <= i_a;
                     b_q     <= i_b;
                     carry_q <= op_is_arith(i_op) ? i_carry_in : 1'b0;
                     idx_q   <= 2'd0;
                     res_q   <= '0;
                     zero_q  <= 1'b1;
                     o_err   <= 1'b0;
                  end else begin
                     o_result       <= '0;
                     o_carry_borrow <= 1'b0;
                     o_overflow     <= 1'b0;
                     o_neg          <= 1'b0;
                     o_zero         <= 1'b0;
                     o_err          <= 1'b1;
                     o_done         <= 1'b1;
                  end
               end
            end
            CAPT: begin
               if (!abort) begin
                  res_q   <= res_next;
                  carry_q <= alu_c;
                  zero_q  <= zero_q & alu_z;
                  if (last_byte) begin
                     o_result       <= res_next;
                     o_carry_borrow <= op_is_arith(op_q) & alu_c;
                     o_overflow     <= op_is_arith(op_q) & alu_v;
                     o_neg          <= res_next[len_q][7];
                     o_zero         <= zero_q & alu_z;
                     o_done         <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mb_alu_ctrl.sv
// Self-checking bench for mb_alu_ctrl: directed cases plus randomized
// operations compared against a whole-word arithmetic reference model.
module tb_mb_alu_ctrl;

   localparam int W = 32;

   logic         i_clk      = 1'b0;
   logic         i_rst_n    = 1'b0;
   logic         i_start    = 1'b0;
   logic [2:0]   i_op       = 3'd0;
   logic [1:0]   i_len      = 2'd0;
   logic [W-1:0] i_a        = '0;
   logic [W-1:0] i_b        = '0;
   logic         i_carry_in = 1'b0;
`ifdef MB_ALU_CTRL_ABORT_EN
   logic         i_abort    = 1'b0;
`endif
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_result;
   logic         o_carry_borrow;
   logic         o_overflow;
   logic         o_neg;
   logic         o_zero;
   logic         o_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        n;
      logic        z;
      logic        err;
   } exp_t;

   exp_t last_exp;

   always #5 i_clk = ~i_clk;

   mb_alu_ctrl dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_op           (i_op),
      .i_len          (i_len),
      .i_a            (i_a),
      .i_b            (i_b),
      .i_carry_in     (i_carry_in),
`ifdef MB_ALU_CTRL_ABORT_EN
      .i_abort        (i_abort),
`endif
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_result       (o_result),
      .o_carry_borrow (o_carry_borrow),
      .o_overflow     (o_overflow),
      .o_neg          (o_neg),
      .o_zero         (o_zero),
      .o_err          (o_err)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: treat the active bytes as one (8*N)-bit word.
   function automatic exp_t model(input logic [2:0] op, input logic [1:0] len,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic cin);
      exp_t            e;
      longint unsigned am, bm, mask, full, r, cm;
      int              bits;
      logic            sa, sb, sr;
      e = '0;
      if (op > 3'd4) begin
         e.err = 1'b1;
         return e;
      end
      bits = 8 * (int'(len) + 1);
      mask = (64'd1 << bits) - 64'd1;
      am   = 64'(a) & mask;
      bm   = 64'(b) & mask;
      cm   = 64'(cin);
      full = 64'd0;
      case (op)
         3'd0: begin
            full = am + bm + cm;
            e.c  = ((full >> bits) & 64'd1) != 64'd0;
         end
         3'd1: begin
            full = am - bm - cm;
            e.c  = am < (bm + cm);
         end
         3'd2:    full = am & bm;
         3'd3:    full = am | bm;
         default: full = am ^ bm;
      endcase
      r     = full & mask;
      e.res = r[31:0];
      sa    = ((am >> (bits - 1)) & 64'd1) != 64'd0;
      sb    = ((bm >> (bits - 1)) & 64'd1) != 64'd0;
      sr    = ((r  >> (bits - 1)) & 64'd1) != 64'd0;
      if (op == 3'd0) e.v = (sa == sb) && (sr != sa);
      if (op == 3'd1) e.v = (sa != sb) && (sr != sa);
      e.n = sr;
      e.z = (r == 64'd0);
      return e;
   endfunction

   // Called at posedge+1. Start is sampled on the next edge; for the first
   // 'hold' edges after that, i_start stays high with a reserved op-code.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input int hold);
      exp_t e;
      int   edges;
      int   exp_lat;
      e       = model(op, len, a, b, cin);
      exp_lat = (op > 3'd4) ? 0 : 2 * (int'(len) + 1);
      i_start    = 1'b1;
      i_op       = op;
      i_len      = len;
      i_a        = a;
      i_b        = b;
      i_carry_in = cin;
      @(posedge i_clk);
      #1;
      i_a        = $urandom;
      i_b        = $urandom;
      i_carry_in = ~cin;
      if (hold > 0) i_op = 3'b101;
      else          i_start = 1'b0;
      check_val({tag, "_busy_start"}, 64'(o_busy), 64'(op <= 3'd4));
      edges = 0;
      while (!o_done && edges < 40) begin
         @(posedge i_clk);
         #1;
         edges++;
         if (edges >= hold) i_start = 1'b0;
      end
      i_start = 1'b0;
      check_val({tag, "_lat"},  64'(edges),          64'(exp_lat));
      check_val({tag, "_busy"}, 64'(o_busy),         64'd0);
      check_val({tag, "_res"},  64'(o_result),       64'(e.res));
      check_val({tag, "_c"},    64'(o_carry_borrow), 64'(e.c));
      check_val({tag, "_v"},    64'(o_overflow),     64'(e.v));
      check_val({tag, "_n"},    64'(o_neg),          64'(e.n));
      check_val({tag, "_z"},    64'(o_zero),         64'(e.z));
      check_val({tag, "_err"},  64'(o_err),          64'(e.err));
      last_exp = e;
   endtask

   // Idle cycles: done must drop and outputs must hold.
   task automatic idle_check(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(posedge i_clk);
         #1;
         check_val("hold_done", 64'(o_done),   64'd0);
         check_val("hold_res",  64'(o_result), 64'(last_exp.res));
         check_val("hold_err",  64'(o_err),    64'(last_exp.err));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rop;
      repeat (2) @(posedge i_clk);
      #1;
      check_val("rst_busy", 64'(o_busy),   64'd0);
      check_val("rst_done", 64'(o_done),   64'd0);
      check_val("rst_res",  64'(o_result), 64'd0);
      check_val("rst_flags", 64'({o_carry_borrow, o_overflow, o_neg, o_zero, o_err}), 64'd0);
      i_rst_n = 1'b1;

      // Start on the first edge after reset release.
      run_op("add16", 3'd0, 2'd1, 32'hAB00_00FF, 32'h0000_0001, 1'b0, 0);
      check_val("add16_lit", 64'(o_result), 64'h0100);
      run_op("sub32", 3'd1, 2'd3, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
      check_val("sub32_lit", 64'({o_result, o_carry_borrow, o_neg, o_overflow}), 64'({32'hFFFF_FFFF, 3'b110}));
      run_op("ovf16", 3'd0, 2'd1, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 0);
      check_val("ovf16_lit", 64'({o_result, o_overflow, o_neg}), 64'({32'h8000, 2'b11}));
      run_op("ovf8", 3'd0, 2'd0, 32'h0000_007F, 32'h0000_0001, 1'b0, 0);
      check_val("ovf8_lit", 64'({o_result, o_overflow}), 64'({32'h80, 1'b1}));
      run_op("xor16", 3'd4, 2'd1, 32'h0000_1234, 32'h0000_1234, 1'b1, 0);
      check_val("xor16_lit", 64'({o_result, o_zero, o_carry_borrow}), 64'({32'h0, 2'b10}));
      run_op("and16", 3'd2, 2'd1, 32'h0000_0100, 32'h0000_01FF, 1'b0, 0);
      check_val("and16_lit", 64'({o_result, o_zero}), 64'({32'h0100, 1'b0}));
      run_op("err", 3'd5, 2'd3, 32'h1234_5678, 32'h1, 1'b0, 0);
      check_val("err_lit", 64'({o_result, o_err}), 64'({32'h0, 1'b1}));
      idle_check(2);
      // Start held high with a reserved op while busy must be ignored.
      run_op("busyign", 3'd1, 2'd3, 32'h0000_0000, 32'h0000_0001, 1'b0, 4);
      idle_check(1);

      // Reset in CAPT of byte 1 of a 32-bit add.
      run_op("pre_rst", 3'd0, 2'd1, 32'h0000_1234, 32'h0000_1111, 1'b0, 0);
      i_start = 1'b1;
      i_op    = 3'd0;
      i_len   = 2'd3;
      i_a     = 32'h1111_1111;
      i_b     = 32'h2222_2222;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (3) begin
         @(posedge i_clk);
         #1;
      end
      i_rst_n = 1'b0;
      #1;
      check_val("midrst_busy", 64'(o_busy),   64'd0);
      check_val("midrst_res",  64'(o_result), 64'd0);
      check_val("midrst_done", 64'(o_done),   64'd0);
      check_val("midrst_flags", 64'({o_carry_borrow, o_overflow, o_neg, o_zero, o_err}), 64'd0);
      #2;
      i_rst_n = 1'b1;
      run_op("post_rst", 3'd0, 2'd1, 32'hFFFF_8001, 32'hFFFF_7FFF, 1'b1, 0);

      // Randomized operations, back-to-back or with idle gaps.
      for (int t = 0; t < 200; t++) begin
         rop = 3'($urandom_range(0, 5));
         if (rop == 3'd5) rop = 3'($urandom_range(5, 7));
         run_op("rnd", rop, 2'($urandom_range(0, 3)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 0);
         if ($urandom_range(0, 3) == 0) idle_check(int'($urandom_range(1, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
